// File: rtl/mcs4_fetch_sequencer.sv
// MCS-4 style fetch front end: phi2-driven phase sequencer, PC/address drive, opcode assembly, return stack.
// Optional `STACK_CHECK_EN adds the stack depth counter and the stack_err_o pulse.
module mcs4_fetch_sequencer #(
    parameter int ADDR_NIBBLES = 3,
    parameter int STACK_DEPTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      RESET_i,
    input  logic                      phi1_i,
    input  logic                      phi2_i,
    input  logic [3:0]                d_i,
    output logic [3:0]                d_o,
    output logic                      d_oe_o,
    output logic                      sync_o,
    output logic [3:0]                phase_o,
    output logic                      instr_valid_o,
    output logic [3:0]                opr_o,
    output logic [3:0]                opa_o,
    output logic [4*ADDR_NIBBLES-1:0] operand_o,
    output logic                      two_word_o,
    output logic [4*ADDR_NIBBLES-1:0] pc_o,
    input  logic                      jump_i,
    input  logic                      call_i,
    input  logic                      ret_i,
    input  logic [4*ADDR_NIBBLES-1:0] jump_addr_i,
    output logic                      stack_err_o
);

    localparam int PW  = 4 * ADDR_NIBBLES;
    localparam int SPW = $clog2(STACK_DEPTH);
    localparam logic [3:0] PH_M1 = 4'(ADDR_NIBBLES);
    localparam logic [3:0] PH_M2 = 4'(ADDR_NIBBLES + 1);
    localparam logic [3:0] PH_X3 = 4'(ADDR_NIBBLES + 4);

    function automatic logic is_two_word(input logic [7:0] w);
        logic [3:0] hi;
        hi = w[7:4];
        return (hi == 4'h1) || (hi == 4'h4) || (hi == 4'h5) || (hi == 4'h7) ||
               ((hi == 4'h2) && (w[0] == 1'b0));
    endfunction

    logic           phi1_prev_q, phi2_prev_q;
    logic           phi2_rise_s;
    logic           phi1_rise_unused_s;
    logic [3:0]     phase_q, phase_d;
    logic [PW-1:0]  pc_q, pc_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [PW-1:0]  stack_q [STACK_DEPTH];
    logic [PW-1:0]  stack_d [STACK_DEPTH];
    logic           pending_q, pending_d;
    logic [3:0]     w1_opr_q, w1_opr_d, w1_opa_q, w1_opa_d;
    logic [3:0]     opr_hi_q, opr_hi_d;
    logic [7:0]     word_s;
    logic [3:0]     d_o_q, d_o_d;
    logic           d_oe_q, d_oe_d;
    logic           sync_q, sync_d;
    logic           valid_q, valid_d;
    logic [3:0]     opr_q, opr_d, opa_q, opa_d;
    logic [PW-1:0]  operand_q, operand_d;
    logic           two_word_q, two_word_d;
`ifdef STACK_CHECK_EN
    localparam int DW = $clog2(STACK_DEPTH + 1);
    logic [DW-1:0]  depth_q, depth_d;
    logic           err_q, err_d;
`endif

    assign phi2_rise_s        = phi2_i & ~phi2_prev_q;
    assign phi1_rise_unused_s = phi1_i & ~phi1_prev_q;

    // Previous-value registers for bus clock edge detection
    always_ff @(posedge clk_i or posedge RESET_i) begin
        if (RESET_i) begin
            phi1_prev_q <= 1'b0;
            phi2_prev_q <= 1'b0;
        end else begin
            phi1_prev_q <= phi1_i;
            phi2_prev_q <= phi2_i;
        end
    end

    // Phase sequencing, PC update, opcode assembly and stack control
    always_comb begin
        phase_d    = phase_q;
        pc_d       = pc_q;
        sp_d       = sp_q;
        stack_d    = stack_q;
        pending_d  = pending_q;
        w1_opr_d   = w1_opr_q;
        w1_opa_d   = w1_opa_q;
        opr_hi_d   = opr_hi_q;
        d_o_d      = d_o_q;
        d_oe_d     = d_oe_q;
        sync_d     = sync_q;
        valid_d    = 1'b0;
        opr_d      = opr_q;
        opa_d      = opa_q;
        operand_d  = operand_q;
        two_word_d = two_word_q;
`ifdef STACK_CHECK_EN
        depth_d    = depth_q;
        err_d      = 1'b0;
`endif
        word_s     = {opr_hi_q, d_i};
        if (phi2_rise_s) begin
            phase_d = (phase_q == PH_X3) ? 4'd0 : phase_q + 4'd1;
            case (phase_q)
                PH_M1: opr_hi_d = d_i;
                PH_M2: begin
                    pc_d = pc_q + PW'(1);
                    if (pending_q) begin
                        valid_d    = 1'b1;
                        opr_d      = w1_opr_q;
                        opa_d      = w1_opa_q;
                        operand_d  = PW'({w1_opa_q, word_s});
                        two_word_d = 1'b1;
                        pending_d  = 1'b0;
                    end else if (is_two_word(word_s)) begin
                        pending_d = 1'b1;
                        w1_opr_d  = word_s[7:4];
                        w1_opa_d  = word_s[3:0];
                    end else begin
                        valid_d    = 1'b1;
                        opr_d      = word_s[7:4];
                        opa_d      = word_s[3:0];
                        operand_d  = '0;
                        two_word_d = 1'b0;
                    end
                end
                PH_X3: begin
                    // ret outranks call; a call dropped by a concurrent ret never flags overflow
                    if (ret_i) begin
                        sp_d = sp_q - SPW'(1);
                        pc_d = stack_q[sp_q - SPW'(1)];
`ifdef STACK_CHECK_EN
                        if (depth_q == '0) err_d = 1'b1;
                        else depth_d = depth_q - DW'(1);
`endif
                    end else if (call_i) begin
                        stack_d[sp_q] = pc_q;
                        sp_d = sp_q + SPW'(1);
                        pc_d = jump_addr_i;
`ifdef STACK_CHECK_EN
                        if (depth_q == DW'(STACK_DEPTH)) err_d = 1'b1;
                        else depth_d = depth_q + DW'(1);
`endif
                    end else if (jump_i) begin
                        pc_d = jump_addr_i;
                    end else begin
                        pc_d = pc_q;
                    end
                    pending_d = (ret_i | call_i | jump_i) ? 1'b0 : pending_q;
                end
                default: pc_d = pc_q;
            endcase
            d_oe_d = (phase_d < PH_M1);
            sync_d = (phase_d != PH_X3);
            if (phase_d < PH_M1) d_o_d = 4'(pc_d >> {phase_d, 2'b00});
            else d_o_d = d_o_q;
        end else begin
            phase_d = phase_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge RESET_i) begin
        if (RESET_i) begin
            phase_q    <= PH_X3;
            pc_q       <= '0;
            sp_q       <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
            pending_q  <= 1'b0;
            w1_opr_q   <= 4'h0;
            w1_opa_q   <= 4'h0;
            opr_hi_q   <= 4'h0;
            d_o_q      <= 4'h0;
            d_oe_q     <= 1'b0;
            sync_q     <= 1'b0;
            valid_q    <= 1'b0;
            opr_q      <= 4'h0;
            opa_q      <= 4'h0;
            operand_q  <= '0;
            two_word_q <= 1'b0;
`ifdef STACK_CHECK_EN
            depth_q    <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            phase_q    <= phase_d;
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
            pending_q  <= pending_d;
            w1_opr_q   <= w1_opr_d;
            w1_opa_q   <= w1_opa_d;
            opr_hi_q   <= opr_hi_d;
            d_o_q      <= d_o_d;
            d_oe_q     <= d_oe_d;
            sync_q     <= sync_d;
            valid_q    <= valid_d;
            opr_q      <= opr_d;
            opa_q      <= opa_d;
            operand_q  <= operand_d;
            two_word_q <= two_word_d;
`ifdef STACK_CHECK_EN
            depth_q    <= depth_d;
            err_q      <= err_d;
`endif
        end
    end

    assign d_o           = d_o_q;
    assign d_oe_o        = d_oe_q;
    assign sync_o        = sync_q;
    assign phase_o       = phase_q;
    assign instr_valid_o = valid_q;
    assign opr_o         = opr_q;
    assign opa_o         = opa_q;
    assign operand_o     = operand_q;
    assign two_word_o    = two_word_q;
    assign pc_o          = pc_q;
`ifdef STACK_CHECK_EN
    assign stack_err_o   = err_q;
`else
    assign stack_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mcs4_fetch_sequencer.sv
// Scoreboard bench for mcs4_fetch_sequencer: driver pushes expectations from a cycle-level model, monitor pops.
module tb_mcs4_fetch_sequencer;

    localparam int AN  = 3;
    localparam int SD  = 4;
    localparam int PW  = 4 * AN;
    localparam int X3  = AN + 4;

    logic          clk_i = 1'b0;
    logic          RESET_i;
    logic          phi1_i, phi2_i;
    logic [3:0]    d_i;
    logic [3:0]    d_o;
    logic          d_oe_o, sync_o, instr_valid_o, two_word_o, stack_err_o;
    logic [3:0]    phase_o, opr_o, opa_o;
    logic [PW-1:0] operand_o, pc_o, jump_addr_i;
    logic          jump_i, call_i, ret_i;

    mcs4_fetch_sequencer #(.ADDR_NIBBLES(AN), .STACK_DEPTH(SD)) dut (
        .clk_i(clk_i), .RESET_i(RESET_i), .phi1_i(phi1_i), .phi2_i(phi2_i),
        .d_i(d_i), .d_o(d_o), .d_oe_o(d_oe_o), .sync_o(sync_o), .phase_o(phase_o),
        .instr_valid_o(instr_valid_o), .opr_o(opr_o), .opa_o(opa_o),
        .operand_o(operand_o), .two_word_o(two_word_o), .pc_o(pc_o),
        .jump_i(jump_i), .call_i(call_i), .ret_i(ret_i), .jump_addr_i(jump_addr_i),
        .stack_err_o(stack_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]    opr;
        logic [3:0]    opa;
        logic [PW-1:0] operand;
        logic [PW-1:0] pc;
        logic          two;
    } iss_t;

    iss_t       iss_q[$];
    logic [3:0] nib_q[$];
    int         err_q[$];
    int         errors = 0;
    int         checks = 0;
    int         exp_phase;
    int         prev_phase;
    int         cyc = 0;
    bit         mon_en = 1'b0;

    // reference model state
    logic [PW-1:0] m_pc;
    logic [PW-1:0] m_stk [SD];
    int            m_sp, m_depth;
    bit            m_pend;
    logic [3:0]    m_w1hi, m_w1lo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit two_word_op(input logic [3:0] hi, input logic [3:0] lo);
        return (hi == 4'h1) || (hi == 4'h4) || (hi == 4'h5) || (hi == 4'h7) ||
               (hi == 4'h2 && lo[0] == 1'b0);
    endfunction

    task automatic model_reset();
        m_pc = '0; m_sp = 0; m_depth = 0; m_pend = 1'b0; m_w1hi = 4'h0; m_w1lo = 4'h0;
        for (int i = 0; i < SD; i++) m_stk[i] = '0;
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("phase", 32'(phase_o), 32'(exp_phase));
            chk("sync", 32'(sync_o), 32'(exp_phase != X3));
            chk("d_oe", 32'(d_oe_o), 32'(exp_phase < AN));
            if (int'(phase_o) != prev_phase && int'(phase_o) < AN) begin
                if (nib_q.size() == 0) chk("nibble_underrun", 32'd1, 32'd0);
                else chk("d_o", 32'(d_o), 32'(nib_q.pop_front()));
            end
            prev_phase = int'(phase_o);
            if (instr_valid_o) begin
                if (iss_q.size() == 0) chk("unexpected_issue", 32'd1, 32'd0);
                else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    chk("opr", 32'(opr_o), 32'(e.opr));
                    chk("opa", 32'(opa_o), 32'(e.opa));
                    chk("operand", 32'(operand_o), 32'(e.operand));
                    chk("two_word", 32'(two_word_o), 32'(e.two));
                    chk("issue_pc", 32'(pc_o), 32'(e.pc));
                end
            end
            if (stack_err_o) begin
                if (err_q.size() == 0) chk("unexpected_stack_err", 32'd1, 32'd0);
                else chk("stack_err_cycle", 32'(cyc), 32'(err_q.pop_front()));
            end
        end
    end

    task automatic step(input logic [3:0] d);
        d_i = d;
        @(negedge clk_i);
        phi2_i = 1'b1; phi1_i = 1'b0;
        @(posedge clk_i);
        #1;
        exp_phase = (exp_phase == X3) ? 0 : exp_phase + 1;
        repeat ($urandom_range(0, 1)) @(negedge clk_i);
        @(negedge clk_i);
        phi2_i = 1'b0; phi1_i = 1'b1;
        repeat ($urandom_range(0, 1)) @(negedge clk_i);
    endtask

    task automatic do_reset_mid();
        @(posedge clk_i);
        #2;
        RESET_i = 1'b1;
        exp_phase = X3;
        #1;
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_phase", 32'(phase_o), 32'(X3));
        chk("rst_d_o", 32'(d_o), 32'd0);
        chk("rst_d_oe", 32'(d_oe_o), 32'd0);
        chk("rst_sync", 32'(sync_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_err", 32'(stack_err_o), 32'd0);
        chk("rst_opr_opa", 32'({opr_o, opa_o}), 32'd0);
        chk("rst_operand", 32'(operand_o), 32'd0);
        chk("rst_two_word", 32'(two_word_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        RESET_i = 1'b0;
    endtask

    task automatic run_cycle(input logic [3:0] m1, input logic [3:0] m2, input bit r, input bit c,
                             input bit j, input logic [PW-1:0] addr, input bit rst_m2);
        logic [PW-1:0] tmp;
        cyc++;
        if (r) begin
`ifdef STACK_CHECK_EN
            if (m_depth == 0) err_q.push_back(cyc);
`endif
            if (m_depth > 0) m_depth--;
            m_sp = (m_sp + SD - 1) % SD;
            m_pc = m_stk[m_sp];
        end else if (c) begin
`ifdef STACK_CHECK_EN
            if (m_depth == SD) err_q.push_back(cyc);
`endif
            if (m_depth < SD) m_depth++;
            m_stk[m_sp] = m_pc;
            m_sp = (m_sp + 1) % SD;
            m_pc = addr;
        end else if (j) begin
            m_pc = addr;
        end
        if (r || c || j) m_pend = 1'b0;
        tmp = m_pc;
        for (int k = 0; k < AN; k++) nib_q.push_back(tmp[4*k +: 4]);
        ret_i = r; call_i = c; jump_i = j; jump_addr_i = addr;
        step(4'($urandom));
        ret_i = 1'b0; call_i = 1'b0; jump_i = 1'b0; jump_addr_i = PW'($urandom);
        for (int k = 1; k < AN; k++) step(4'($urandom));
        step(4'($urandom));
        step(m1);
        if (rst_m2) begin
            do_reset_mid();
            return;
        end
        m_pc = m_pc + PW'(1);
        if (m_pend) begin
            iss_q.push_back('{opr: m_w1hi, opa: m_w1lo, operand: PW'({m_w1lo, m1, m2}), pc: m_pc, two: 1'b1});
            m_pend = 1'b0;
        end else if (two_word_op(m1, m2)) begin
            m_pend = 1'b1; m_w1hi = m1; m_w1lo = m2;
        end else begin
            iss_q.push_back('{opr: m1, opa: m2, operand: '0, pc: m_pc, two: 1'b0});
        end
        step(m2);
        step(4'($urandom));
        step(4'($urandom));
    endtask

    initial begin
        RESET_i = 1'b1; phi1_i = 1'b0; phi2_i = 1'b0; d_i = 4'h0;
        jump_i = 1'b0; call_i = 1'b0; ret_i = 1'b0; jump_addr_i = '0;
        exp_phase = X3; prev_phase = X3;
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("init_phase", 32'(phase_o), 32'(X3));
        chk("init_sync", 32'(sync_o), 32'd0);
        chk("init_pc", 32'(pc_o), 32'd0);
        chk("init_d_oe", 32'(d_oe_o), 32'd0);
        RESET_i = 1'b0;
        mon_en = 1'b1;

        run_cycle(4'hD, 4'h5, 0, 0, 0, '0, 0);
        run_cycle(4'h4, 4'h2, 0, 0, 0, '0, 0);
        run_cycle(4'h3, 4'h4, 0, 0, 0, '0, 0);
        run_cycle(4'h0, 4'h0, 0, 0, 1, PW'(4), 0);
        run_cycle(4'hA, 4'h1, 0, 1, 0, PW'(12'h123), 0);
        run_cycle(4'hB, 4'h2, 1, 0, 0, '0, 0);
        for (int i = 0; i < 5; i++) run_cycle(4'hC, 4'(i), 0, 1, 0, PW'($urandom), 0);
        for (int i = 0; i < 4; i++) run_cycle(4'hE, 4'(i), 1, 0, 0, '0, 0);
        run_cycle(4'h2, 4'h0, 0, 0, 0, '0, 0);
        run_cycle(4'h3, 4'h4, 0, 0, 1, PW'(9), 0);
        run_cycle(4'h6, 4'h6, 0, 0, 1, '1, 0);
        run_cycle(4'h7, 4'h7, 0, 0, 0, '0, 0);
        run_cycle(4'h9, 4'h9, 0, 0, 0, '0, 1);
        run_cycle(4'hD, 4'h5, 0, 0, 0, '0, 0);
        run_cycle(4'h8, 4'h8, 0, 1, 0, PW'(12'h456), 0);
        run_cycle(4'h8, 4'h9, 1, 1, 0, PW'(12'h789), 0);
        for (int i = 0; i < 200; i++)
            run_cycle(4'($urandom), 4'($urandom), $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, PW'($urandom), 0);
        repeat (10) @(negedge clk_i);
        chk("issues_left", 32'(iss_q.size()), 32'd0);
        chk("nibbles_left", 32'(nib_q.size()), 32'd0);
        chk("errs_left", 32'(err_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
